qam16_frame_sync: RTL and testbench

QAM16_FRAME_SYNC -- requirements
Module: qam16_frame_sync

---
 rtl/qam16_frame_sync.sv | 182 ++++++++++++++++++
 tb/tb_qam16_frame_sync.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_frame_sync.sv
// qam16_frame_sync
//   Hard-decision 16-QAM slicer followed by a sync-word frame aligner.
//   Each strobed I/Q sample pair is sliced to a 4-bit symbol {I bits, Q bits}.
//   The last four symbols are compared against SYNC_WORD to acquire, confirm
//   and track frame alignment (HUNT -> CHECK -> LOCK). Lock is dropped after
//   LOCK_MISS consecutive missed sync words.
//
//   Optional feature: define QAM16_FRAME_SYNC_ERR_EN to build the slicer error
//   accumulator. Without it, err_acc is tied to zero.
//
// Ports
//   clk           : single clock
//   rst_clk       : synchronous active-high reset
//   sym_stb       : one symbol per high cycle
//   i_in, q_in    : signed DW-bit samples, valid while sym_stb=1
//   sym_out       : sliced symbol {I[1:0], Q[1:0]}, held until the next symbol
//   sym_valid     : one-cycle pulse qualifying sym_out
//   locked        : high while aligned (LOCK)
//   frame_start   : pulse with the sym_valid of the last symbol of a confirmed sync word
//   payload_valid : sym_valid while locked and outside the sync positions 0..3
//   err_acc       : saturating |x - ideal| sum, cleared on frame_start
module qam16_frame_sync #(
  parameter int          DW        = 12,
  parameter int          THR       = 512,
  parameter logic [15:0] SYNC_WORD = 16'hF0A5,
  parameter int          FRAME_LEN = 64,
  parameter int          LOCK_MISS = 3
) (
  input  logic          clk,
  input  logic          rst_clk,
  input  logic          sym_stb,
  input  logic [DW-1:0] i_in,
  input  logic [DW-1:0] q_in,
  output logic [3:0]    sym_out,
  output logic          sym_valid,
  output logic          locked,
  output logic          frame_start,
  output logic          payload_valid,
  output logic [15:0]   err_acc
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

  localparam logic signed [31:0] THR_S = 32'(THR);

  state_t      state;
  logic [15:0] history;
  logic [7:0]  sym_idx;
  logic [7:0]  miss_cnt;

  logic signed [31:0] i_ext;
  logic signed [31:0] q_ext;
  logic [3:0]         sym_new;
  logic [15:0]        hist_next;
  logic               sync_hit;
  logic [7:0]         idx_next;
  logic               boundary;
  logic               frame_hit;

  function automatic logic [1:0] slice_axis(input logic signed [31:0] x);
    if (x >= THR_S)       return 2'b10;
    else if (x >= 0)      return 2'b11;
    else if (x >= -THR_S) return 2'b01;
    else                  return 2'b00;
  endfunction

  assign i_ext   = {{(32-DW){i_in[DW-1]}}, i_in};
  assign q_ext   = {{(32-DW){q_in[DW-1]}}, q_in};
  assign sym_new = {slice_axis(i_ext), slice_axis(q_ext)};

  // Sync detection looks at the history including the symbol arriving now, so
  // frame_start lands on the same edge that registers the last sync symbol.
  assign hist_next = {history[11:0], sym_new};
  assign sync_hit  = (hist_next == SYNC_WORD);
  assign idx_next  = (sym_idx == 8'(FRAME_LEN - 1)) ? 8'd0 : sym_idx + 8'd1;
  assign boundary  = (idx_next == 8'd3);
  assign frame_hit = boundary && sync_hit && (state != HUNT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: every register, including the symbol history, is cleared by reset;
    // a partial frame must not leak into the next sync search.
    if (rst_clk) begin
      state         <= HUNT;
      history       <= '0;
      sym_idx       <= '0;
      miss_cnt      <= '0;
      sym_out       <= '0;
      sym_valid     <= 1'b0;
      locked        <= 1'b0;
      frame_start   <= 1'b0;
      payload_valid <= 1'b0;
    end else begin
      sym_valid     <= sym_stb;
      frame_start   <= 1'b0;
      payload_valid <= 1'b0;
      if (sym_stb) begin
        sym_out <= sym_new;
        history <= hist_next;
        sym_idx <= idx_next;
        // State changes only happen at index 3, which is never a payload
        // position, so the current state qualifies the payload correctly.
        payload_valid <= (state == LOCK) && (idx_next >= 8'd4);
        case (state)
          HUNT: begin
            if (sync_hit) begin
              state   <= CHECK;
              sym_idx <= 8'd3;
            end
          end
          CHECK: begin
            if (boundary) begin
              if (sync_hit) begin
                state       <= LOCK;
                locked      <= 1'b1;
                frame_start <= 1'b1;
                miss_cnt    <= '0;
              end else begin
                state <= HUNT;
              end
            end
          end
          LOCK: begin
            // Off-boundary matches are deliberately ignored: alignment is
            // only ever re-established from HUNT.
            if (boundary) begin
              if (sync_hit) begin
                frame_start <= 1'b1;
                miss_cnt    <= '0;
              end else if (miss_cnt + 8'd1 >= 8'(LOCK_MISS)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                miss_cnt <= '0;
              end else begin
                miss_cnt <= miss_cnt + 8'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef QAM16_FRAME_SYNC_ERR_EN
  localparam logic signed [31:0] THR_HALF  = THR_S >>> 1;
  localparam logic signed [31:0] THR3_HALF = (THR_S * 3) >>> 1;

  // Distance from the sample to the ideal constellation level of its region.
  function automatic logic [31:0] axis_err(input logic signed [31:0] x,
                                           input logic [1:0] s);
    logic signed [31:0] ideal;
    logic signed [31:0] d;
    case (s)
      2'b10:   ideal = THR3_HALF;
      2'b11:   ideal = THR_HALF;
      2'b01:   ideal = -THR_HALF;
      default: ideal = -THR3_HALF;
    endcase
    d = x - ideal;
    return (d < 0) ? 32'(-d) : 32'(d);
  endfunction

  logic [31:0] err_sum;
  assign err_sum = 32'(err_acc) + axis_err(i_ext, sym_new[3:2])
                                + axis_err(q_ext, sym_new[1:0]);

  always_ff @(posedge clk) begin
    if (rst_clk) begin
      err_acc <= '0;
    end else if (sym_stb) begin
      if (frame_hit)                    err_acc <= '0;
      else if (err_sum > 32'h0000_FFFF) err_acc <= 16'hFFFF;
      else                              err_acc <= err_sum[15:0];
    end
  end
`else
  assign err_acc = '0;
`endif

endmodule

// File: tb/tb_qam16_frame_sync.sv
// tb_qam16_frame_sync
//   Randomized self-checking bench for qam16_frame_sync with default
//   parameters. A per-symbol reference model (plain integer arithmetic on
//   sample values, frame position and miss counts) predicts every output,
//   which is compared one cycle after each stimulus on the falling edge.
//   Directed scenarios cover slicing, acquisition, loss of lock, false sync,
//   back-to-back strobes, mid-frame reset and, with QAM16_FRAME_SYNC_ERR_EN,
//   the error accumulator.
module tb_qam16_frame_sync;

  localparam int          DW        = 12;
  localparam int          THR       = 512;
  localparam logic [15:0] SYNC      = 16'hF0A5;
  localparam int          FRAME_LEN = 64;
  localparam int          LOCK_MISS = 3;

  localparam int M_HUNT  = 0;
  localparam int M_CHECK = 1;
  localparam int M_LOCK  = 2;

  logic          clk     = 1'b0;
  logic          rst_clk = 1'b1;
  logic          sym_stb = 1'b0;
  logic [DW-1:0] i_in    = '0;
  logic [DW-1:0] q_in    = '0;
  logic [3:0]    sym_out;
  logic          sym_valid;
  logic          locked;
  logic          frame_start;
  logic          payload_valid;
  logic [15:0]   err_acc;

  qam16_frame_sync #(
    .DW        (DW),
    .THR       (THR),
    .SYNC_WORD (SYNC),
    .FRAME_LEN (FRAME_LEN),
    .LOCK_MISS (LOCK_MISS)
  ) dut (
    .clk           (clk),
    .rst_clk       (rst_clk),
    .sym_stb       (sym_stb),
    .i_in          (i_in),
    .q_in          (q_in),
    .sym_out       (sym_out),
    .sym_valid     (sym_valid),
    .locked        (locked),
    .frame_start   (frame_start),
    .payload_valid (payload_valid),
    .err_acc       (err_acc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state and expected outputs.
  int m_state = M_HUNT;
  int m_idx   = 0;
  int m_miss  = 0;
  int m_hist  = 0;
  int e_sym   = 0;
  int e_valid = 0;
  int e_lock  = 0;
  int e_fs    = 0;
  int e_pv    = 0;
  int e_err   = 0;

  // Pulse counters observed from the DUT.
  int sv_seen = 0;
  int pv_seen = 0;
  int fs_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int slice_m(input int x);
    if (x >= THR)  return 2;
    if (x >= 0)    return 3;
    if (x >= -THR) return 1;
    return 0;
  endfunction

  function automatic int err_m(input int x, input int s);
    int ideal;
    case (s)
      2:       ideal = 3 * THR / 2;
      3:       ideal = THR / 2;
      1:       ideal = -THR / 2;
      default: ideal = -3 * THR / 2;
    endcase
    return (x >= ideal) ? x - ideal : ideal - x;
  endfunction

  // Random sample inside the region that slices to b, sometimes on its edge.
  function automatic int pick(input logic [1:0] b);
    bit edge_pick;
    bit lo;
    edge_pick = ($urandom_range(0, 4) == 0);
    lo        = $urandom_range(0, 1) == 1;
    case (b)
      2'b10:   return edge_pick ? (lo ? THR : 2047) : THR + int'($urandom_range(1535, 0));
      2'b11:   return edge_pick ? (lo ? 0 : THR - 1) : int'($urandom_range(THR - 1, 0));
      2'b01:   return edge_pick ? (lo ? -THR : -1) : -int'($urandom_range(THR, 1));
      default: return edge_pick ? (lo ? -THR - 1 : -2048) : -THR - 1 - int'($urandom_range(1535, 0));
    endcase
  endfunction

  task automatic model_step(input logic stb, input int i, input int q, input logic rst);
    int  s;
    bit  hit;
    bit  fs;
    if (rst) begin
      m_state = M_HUNT; m_idx = 0; m_miss = 0; m_hist = 0;
      e_sym = 0; e_valid = 0; e_lock = 0; e_fs = 0; e_pv = 0; e_err = 0;
    end else begin
      e_valid = stb;
      e_fs    = 0;
      e_pv    = 0;
      if (stb) begin
        s      = slice_m(i) * 4 + slice_m(q);
        e_sym  = s;
        m_hist = (m_hist * 16 + s) % 65536;
        hit    = (m_hist == int'(SYNC));
        m_idx  = (m_idx + 1) % FRAME_LEN;
        fs     = 0;
        if (m_state == M_HUNT) begin
          if (hit) begin
            m_state = M_CHECK;
            m_idx   = 3;
          end
        end else if (m_idx == 3) begin
          if (hit) begin
            m_state = M_LOCK;
            m_miss  = 0;
            fs      = 1;
          end else if (m_state == M_CHECK) begin
            m_state = M_HUNT;
          end else begin
            m_miss++;
            if (m_miss >= LOCK_MISS) begin
              m_state = M_HUNT;
              m_miss  = 0;
            end
          end
        end
        e_lock = (m_state == M_LOCK);
        e_fs   = fs;
        e_pv   = e_lock && (m_idx >= 4);
`ifdef QAM16_FRAME_SYNC_ERR_EN
        if (fs) e_err = 0;
        else begin
          e_err = e_err + err_m(i, slice_m(i)) + err_m(q, slice_m(q));
          if (e_err > 65535) e_err = 65535;
        end
`endif
      end
    end
  endtask

  task automatic compare_outputs();
    check("sym_out",       sym_out,       e_sym);
    check("sym_valid",     sym_valid,     e_valid);
    check("locked",        locked,        e_lock);
    check("frame_start",   frame_start,   e_fs);
    check("payload_valid", payload_valid, e_pv);
    check("err_acc",       err_acc,       e_err);
    sv_seen += int'(sym_valid);
    pv_seen += int'(payload_valid);
    fs_seen += int'(frame_start);
  endtask

  // One clock: check what the previous cycle produced, then drive the next inputs.
  task automatic cycle(input logic stb, input int i, input int q, input logic rst);
    @(negedge clk);
    compare_outputs();
    model_step(stb, i, q, rst);
    rst_clk = rst;
    sym_stb = stb;
    i_in    = DW'(i);
    q_in    = DW'(q);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 0, 1'b0);
  endtask

  task automatic send_sym(input logic [3:0] nib);
    int gap;
    cycle(1'b1, pick(nib[3:2]), pick(nib[1:0]), 1'b0);
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 1)) : 0;
    repeat (gap) idle();
  endtask

  // Payload nibbles exclude 4'hF so the sync word only appears where placed.
  task automatic send_frame(input bit good, input bit false_sync, input int n_syms);
    logic [15:0] sw;
    logic [3:0]  nib;
    sw = SYNC;
    for (int k = 0; k < n_syms; k++) begin
      if (k < 4) nib = sw[15 - 4 * k -: 4];
      else       nib = 4'($urandom_range(14, 0));
      if (k == 0 && !good) nib = nib ^ 4'h1;
      if (false_sync && k >= 17 && k <= 20) nib = sw[15 - 4 * (k - 17) -: 4];
      send_sym(nib);
    end
  endtask

  initial begin
    // Reset state
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    idle();
    check("rst_sym_out",       sym_out,       0);
    check("rst_sym_valid",     sym_valid,     0);
    check("rst_locked",        locked,        0);
    check("rst_frame_start",   frame_start,   0);
    check("rst_payload_valid", payload_valid, 0);
    check("rst_err_acc",       err_acc,       0);

    // Directed slicing and one-cycle latency
    cycle(1'b1, 600, -600, 1'b0);
    idle();
    check("slice_a",       sym_out,   4'b1000);
    check("slice_a_valid", sym_valid, 1);
    idle();
    check("slice_a_hold",  sym_out,   4'b1000);
    check("slice_a_pulse", sym_valid, 0);
    cycle(1'b1, 0, -512, 1'b0);
    idle();
    check("slice_b",       sym_out,   4'b1101);

    // Acquisition: first sync -> CHECK (not locked), second -> LOCK
    send_frame(1, 0, FRAME_LEN);
    idle();
    check("acq_first_unlocked", locked, 0);
    pv_seen = 0; fs_seen = 0;
    send_frame(1, 0, FRAME_LEN);
    idle();
    check("acq_locked",   locked,  1);
    check("acq_fs_count", fs_seen, 1);
    check("acq_payload",  pv_seen, 60);

    // False sync at index 20 is ignored and alignment is kept
    fs_seen = 0;
    send_frame(1, 1, FRAME_LEN);
    idle();
    check("false_sync_fs", fs_seen, 1);
    fs_seen = 0; pv_seen = 0;
    send_frame(1, 0, FRAME_LEN);
    idle();
    check("false_sync_next_fs", fs_seen, 1);
    check("false_sync_payload", pv_seen, 60);
    check("false_sync_locked",  locked,  1);

    // Two misses then a good sync clears the miss count
    send_frame(0, 0, FRAME_LEN);
    send_frame(0, 0, FRAME_LEN);
    send_frame(1, 0, FRAME_LEN);
    send_frame(0, 0, FRAME_LEN);
    send_frame(0, 0, FRAME_LEN);
    idle();
    check("miss_cleared_locked", locked, 1);

    // Three consecutive misses drop lock at the third boundary
    send_frame(1, 0, FRAME_LEN);
    send_frame(0, 0, FRAME_LEN);
    send_frame(0, 0, FRAME_LEN);
    send_frame(0, 0, 3);
    idle();
    check("loss_before_third", locked, 1);
    send_sym(4'h5);
    idle();
    check("loss_at_third", locked, 0);

    // Re-acquire
    send_frame(1, 0, FRAME_LEN);
    send_frame(1, 0, FRAME_LEN);
    idle();
    check("reacq_locked", locked, 1);

    // Mid-frame reset with a strobe during reset
    send_frame(1, 0, 30);
    cycle(1'b1, 600, 600, 1'b1);
    idle();
    check("midrst_sym_out",       sym_out,       0);
    check("midrst_sym_valid",     sym_valid,     0);
    check("midrst_locked",        locked,        0);
    check("midrst_frame_start",   frame_start,   0);
    check("midrst_payload_valid", payload_valid, 0);
    check("midrst_err_acc",       err_acc,       0);
    send_frame(1, 0, FRAME_LEN);
    idle();
    check("midrst_hunt_one_frame", locked, 0);

    // Five back-to-back strobes -> five sym_valid pulses
    idle();
    sv_seen = 0;
    repeat (5) cycle(1'b1, pick(2'($urandom_range(3, 0))), pick(2'($urandom_range(3, 0))), 1'b0);
    idle();
    idle();
    check("b2b_valid_count", sv_seen, 5);

`ifdef QAM16_FRAME_SYNC_ERR_EN
    // Error accumulator: |300-256| + |256-256| = 44
    cycle(1'b0, 0, 0, 1'b1);
    idle();
    cycle(1'b1, 300, 256, 1'b0);
    idle();
    check("err_directed", err_acc, 44);
`endif

    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", tests);
    $fatal(1, "watchdog");
  end

endmodule
